sha256_mblk_ctrl: RTL
=====================

// Module: sha256_mblk_ctrl
// PURPOSE
//  Control FSM for multi-block SHA-256 hashing. It loads the IV once per message and accepts
//  message blocks through a valid/ready handshake. For each block it sequences the working-register
//  init, ROUNDS compression rounds, a settle window and the H+=a..h update. It pulses done after
//  the last block. Drives the round datapath, message schedule and digest registers; owns the round counter.
// PARAMETERS
//  ROUNDS      64  compression rounds per block (2..2**CNT_W)
//  CNT_W        6  round_idx width
//  FIN_CYCLES   1  settle cycles between last round and hash update (0..15; 0 = no FINAL state)
//  BCNT_W      16  blk_count width
// PORTS
//  clk          in   1       clock, rising edge
//  rst_n        in   1       asynchronous active-low reset
//  start        in   1       begin new message (sampled in IDLE only)
//  abort        in   1       synchronous cancel of current message
//  blk_valid    in   1       upstream block available
//  blk_last     in   1       block is final block of message (qualified by blk_valid)
//  blk_ready    out  1       FSM can accept a block
//  init_hash    out  1       load H0..H7 with the SHA-256 IV
//  load_w       out  1       capture block into message schedule
//  init_regs    out  1       load a..h from H0..H7
//  round_en     out  1       execute one round at round_idx
//  round_idx    out  CNT_W   current round number
//  update_hash  out  1       H_i <= H_i + working var
//  busy         out  1       FSM not in IDLE
//  done         out  1       digest valid (1-cycle pulse)
//  aborted      out  1       abort taken (1-cycle pulse)
//  blk_count    out  BCNT_W  blocks completed in current message
// BEHAVIOUR
//  Reset: state=IDLE, round_idx=0, blk_count=0, last_q=0, fin_cnt=0; all 1-bit outputs 0.
//  States: IDLE, WAIT_BLK, INIT, ROUND, FINAL, UPDATE, DONE.
//  IDLE: busy=0. start&!abort -> WAIT_BLK. In the same cycle init_hash=1 (Mealy) and blk_count<=0.
//  WAIT_BLK: blk_ready=1. On blk_valid: load_w=1 (Mealy) and last_q<=blk_last, then -> INIT.
//   Without blk_valid, stay in WAIT_BLK indefinitely.
//  INIT: init_regs=1 for one cycle. round_idx<=0. -> ROUND.
//  ROUND: round_en=1. round_idx increments each cycle.
//   At round_idx==ROUNDS-1, go to FINAL (or UPDATE if FIN_CYCLES==0). round_idx then holds.
//  FINAL: no round_en. Stays exactly FIN_CYCLES cycles (fin_cnt), then -> UPDATE.
//  UPDATE: update_hash=1 for one cycle. blk_count increments and saturates at all-ones.
//   Next state is DONE if last_q, else WAIT_BLK.
//  DONE: done=1 for one cycle. -> IDLE. blk_count holds until the next start.
//  busy=1 in every state except IDLE.
//  Per-block latency from accept edge to update_hash: 1+ROUNDS+FIN_CYCLES cycles.
//   Defaults: 66 cycles. done follows 1 cycle later.
//  round_idx holds outside INIT/ROUND. It never exceeds ROUNDS-1.
//  start outside IDLE is ignored. blk_valid outside WAIT_BLK is ignored (blk_ready=0).
//  abort in any non-IDLE state -> IDLE next edge, with aborted=1 that cycle.
//   It suppresses load_w, update_hash and done in that cycle. H contents are left stale.
//  abort in IDLE is ignored, and takes priority over start (stays IDLE, no init_hash).
//  Async reset mid-operation returns to the reset values immediately. No done, no aborted pulse.
//  Illegal state encodings -> IDLE.
// TESTING
//  1. Single block: start, then blk_valid=1, blk_last=1 at t.
//     -> init_regs at t+1; round_en t+2..t+65 (idx 0..63); FINAL t+66;
//     update_hash t+67; done t+68; blk_count=1.
//  2. Two blocks, second blk_valid delayed 5 cycles. -> blk_ready held high 5 cycles;
//     init_hash only once; update_hash twice; done once; blk_count=2.
//  3. abort at round_idx=20. -> next cycle IDLE; aborted=1; busy=0; no update_hash/done;
//     a new start then runs cleanly.
//  4. start pulsed during ROUND and DONE. -> ignored; no extra init_hash; state sequence unchanged.
//  5. ROUNDS=8, FIN_CYCLES=0, single block accepted at t. -> round_en t+2..t+9;
//     update_hash t+10; done t+11.
//  6. rst_n low during FINAL. -> all outputs 0 and round_idx=0 asynchronously; IDLE after release.

Source files
------------

// File: rtl/sha256_mblk_ctrl_if.sv
// Handshake and control bundle between the multi-block SHA-256 sequencer
// and its environment (block source, round datapath, schedule, digest regs).
interface sha256_mblk_ctrl_if #(
  parameter int CNT_W  = 6,
  parameter int BCNT_W = 16
);
  logic              start;
  logic              abort;
  logic              blk_valid;
  logic              blk_last;
  logic              blk_ready;
  logic              init_hash;
  logic              load_w;
  logic              init_regs;
  logic              round_en;
  logic [CNT_W-1:0]  round_idx;
  logic              update_hash;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [BCNT_W-1:0] blk_count;

  // Environment side: issues commands and blocks, observes control strobes.
  modport master (
    output start, abort, blk_valid, blk_last,
    input  blk_ready, init_hash, load_w, init_regs, round_en, round_idx,
           update_hash, busy, done, aborted, blk_count
  );

  // Controller side.
  modport slave (
    input  start, abort, blk_valid, blk_last,
    output blk_ready, init_hash, load_w, init_regs, round_en, round_idx,
           update_hash, busy, done, aborted, blk_count
  );
endinterface

// File: rtl/sha256_mblk_ctrl.sv
// Multi-block SHA-256 control FSM. Loads the IV once per message, accepts
// blocks over valid/ready, then per block sequences working-register init,
// ROUNDS compression rounds, an optional settle window and the H update.
// init_hash, load_w and aborted are Mealy strobes; the rest decode state.
module sha256_mblk_ctrl #(
  parameter int ROUNDS     = 64,
  parameter int CNT_W      = 6,
  parameter int FIN_CYCLES = 1,
  parameter int BCNT_W     = 16
) (
  input logic               clk,
  input logic               rst_n,
  sha256_mblk_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_INIT   = 3'd2;
  localparam logic [2:0] S_ROUND  = 3'd3;
  localparam logic [2:0] S_FINAL  = 3'd4;
  localparam logic [2:0] S_UPDATE = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(ROUNDS - 1);
  localparam logic [3:0]       FIN_LAST  = (FIN_CYCLES == 0) ? 4'd0 : 4'(FIN_CYCLES - 1);
  localparam bit               HAS_FINAL = (FIN_CYCLES != 0);

  logic [2:0]        r_state;
  logic [CNT_W-1:0]  r_round_idx;
  logic [BCNT_W-1:0] r_blk_count;
  logic              r_last_q;
  logic [3:0]        r_fin_cnt;

  logic [2:0] w_next;
  logic       w_abort_take;
  logic       w_blk_ready;
  logic       w_init_hash;
  logic       w_load_w;
  logic       w_init_regs;
  logic       w_round_en;
  logic       w_update_hash;
  logic       w_done;
  logic       w_aborted;
  logic       w_round_last;

  assign w_abort_take = bus.abort & (r_state != S_IDLE);
  assign w_round_last = (r_round_idx == LAST_IDX);

  // Next-state selection and control strobe decode; abort overrides everything.
  always_comb begin
    w_next        = r_state;
    w_blk_ready   = 1'b0;
    w_init_hash   = 1'b0;
    w_load_w      = 1'b0;
    w_init_regs   = 1'b0;
    w_round_en    = 1'b0;
    w_update_hash = 1'b0;
    w_done        = 1'b0;
    w_aborted     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start & ~bus.abort) begin
          w_next      = S_WAIT;
          w_init_hash = 1'b1;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_WAIT: begin
        w_blk_ready = 1'b1;
        if (bus.blk_valid) begin
          w_load_w = 1'b1;
          w_next   = S_INIT;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_INIT: begin
        w_init_regs = 1'b1;
        w_next      = S_ROUND;
      end
      S_ROUND: begin
        w_round_en = 1'b1;
        if (w_round_last) begin
          w_next = HAS_FINAL ? S_FINAL : S_UPDATE;
        end else begin
          w_next = S_ROUND;
        end
      end
      S_FINAL: begin
        if (r_fin_cnt == FIN_LAST) begin
          w_next = S_UPDATE;
        end else begin
          w_next = S_FINAL;
        end
      end
      S_UPDATE: begin
        w_update_hash = 1'b1;
        w_next        = r_last_q ? S_DONE : S_WAIT;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    if (w_abort_take) begin
      w_next        = S_IDLE;
      w_load_w      = 1'b0;
      w_update_hash = 1'b0;
      w_done        = 1'b0;
      w_aborted     = 1'b1;
    end else begin
      w_aborted = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Round counter: cleared in INIT, advances through ROUND, holds at the last round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_round_idx <= {CNT_W{1'b0}};
    end else if (w_abort_take) begin
      r_round_idx <= r_round_idx;
    end else if (r_state == S_INIT) begin
      r_round_idx <= {CNT_W{1'b0}};
    end else if ((r_state == S_ROUND) && !w_round_last) begin
      r_round_idx <= r_round_idx + CNT_W'(1);
    end else begin
      r_round_idx <= r_round_idx;
    end
  end

  // Settle-window counter: armed while rounds run, counts FINAL cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fin_cnt <= 4'd0;
    end else if ((r_state == S_FINAL) && !w_abort_take && (r_fin_cnt != FIN_LAST)) begin
      r_fin_cnt <= r_fin_cnt + 4'd1;
    end else if (r_state == S_FINAL) begin
      r_fin_cnt <= r_fin_cnt;
    end else begin
      r_fin_cnt <= 4'd0;
    end
  end

  // Remember whether the accepted block closes the message.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_q <= 1'b0;
    end else if ((r_state == S_WAIT) && bus.blk_valid && !w_abort_take) begin
      r_last_q <= bus.blk_last;
    end else begin
      r_last_q <= r_last_q;
    end
  end

  // Completed-block count: cleared on message start, saturating increment per update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blk_count <= {BCNT_W{1'b0}};
    end else if (w_init_hash) begin
      r_blk_count <= {BCNT_W{1'b0}};
    end else if (w_update_hash && (r_blk_count != {BCNT_W{1'b1}})) begin
      r_blk_count <= r_blk_count + BCNT_W'(1);
    end else begin
      r_blk_count <= r_blk_count;
    end
  end

  assign bus.blk_ready   = w_blk_ready;
  assign bus.init_hash   = w_init_hash;
  assign bus.load_w      = w_load_w;
  assign bus.init_regs   = w_init_regs;
  assign bus.round_en    = w_round_en;
  assign bus.round_idx   = r_round_idx;
  assign bus.update_hash = w_update_hash;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = w_done;
  assign bus.aborted     = w_aborted;
  assign bus.blk_count   = r_blk_count;

endmodule
